cam_fifo_burst_ctrl: RTL
========================

Name: cam_fifo_burst_ctrl

Overview:
- Read-side controller for the camera pixel FIFO (32-bit read port, registered-free output: data valid one cycle after rd_en).
- Watches the FIFO read water level and, once a full burst is buffered, issues a frame-buffer write request followed by exactly BURST_LEN data beats.
- Tracks the frame write address, wraps at frame end and resynchronises on camera frame start.
- Sits between the camera FIFO and the DDR frame-buffer write port.

Parameters:
- DATA_WIDTH, 32: FIFO read / write-beat data width.
- LEVEL_WIDTH, 12: width of the FIFO read water level.
- ADDR_WIDTH, 28: word address width.
- BURST_LEN, 64: words per burst; power of 2, 2..256.
- FRAME_BASE, 0: word address of the frame buffer.
- FRAME_WORDS, 153600: words per frame; must be a multiple of BURST_LEN.

Ports:
- clk  in  1  single clock; also the FIFO rd_clk.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at camera vsync.
- fifo_rd_water_level  in  LEVEL_WIDTH  FIFO read-side fill level in words.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  DATA_WIDTH  FIFO data; valid the cycle after fifo_rd_en.
- req_valid  out  1  burst request valid.
- req_ready  in  1  burst request accepted.
- req_addr  out  ADDR_WIDTH  burst start word address.
- req_len  out  8  BURST_LEN-1.
- wdata_valid  out  1  write beat valid.
- wdata_ready  in  1  write beat accepted.
- wdata  out  DATA_WIDTH  write beat data.
- wdata_last  out  1  final beat of the burst.
- frame_done  out  1  one-cycle pulse when the last burst of a frame completes.
- busy  out  1  high in ADDR or DATA state.

Behaviour:
- Reset values: all outputs 0, except req_len, which is the constant BURST_LEN-1. Internal state on reset: address = FRAME_BASE, frame word count = 0, armed = 0, 2-entry beat buffer empty, in-flight flag 0.
- armed is set by the first frame_start. No burst starts until armed = 1.
- IDLE:
  - Apply any pending frame_start: address = FRAME_BASE, count = 0.
  - Go to ADDR when armed and fifo_rd_water_level >= BURST_LEN, sampled in IDLE. req_valid rises on the next cycle.
- ADDR:
  - req_valid = 1 and req_addr stable until req_valid && req_ready.
  - On that edge go to DATA and load the read counter with BURST_LEN.
- DATA:
  - fifo_rd_en = (reads remaining > 0) && !fifo_rd_empty && (occ + inflight - pop) < 2, where pop = wdata_valid && wdata_ready. This is combinational on wdata_ready.
  - Data returns one cycle after fifo_rd_en and enters the beat buffer.
  - wdata and wdata_valid come from the buffer head. wdata_valid holds until accepted; wdata is stable while stalled.
  - Sustains 1 beat/cycle while wdata_ready stays high.
  - wdata_last = 1 on beat number BURST_LEN.
- Burst end (last beat accepted):
  - address += BURST_LEN; count += BURST_LEN.
  - If count reaches FRAME_WORDS: pulse frame_done, address = FRAME_BASE, count = 0.
  - Return to IDLE.
- frame_start in IDLE takes effect on the same edge.
- frame_start during ADDR or DATA:
  - Latched as pending; the burst is never aborted.
  - At burst end the pending frame_start overrides the increment/wrap: address = FRAME_BASE, count = 0, and frame_done is not pulsed unless the wrap also occurred.
- fifo_rd_empty during DATA stalls reads only. The burst completes once data arrives; there is no timeout.
- rst mid-burst: on the same edge, drop req_valid, wdata_valid and fifo_rd_en, and discard buffered and in-flight data. The system resets the FIFO concurrently.
- All address arithmetic is modulo 2^ADDR_WIDTH.

Optional Feature:
- CAM_BURST_PINGPONG_EN defined:
  - Two buffers: FRAME_BASE and FRAME_BASE+FRAME_WORDS.
  - Every applied frame_start toggles the write buffer; the wrap returns to the current buffer's base.
  - Adds output port disp_buf_sel (1 bit, reset 1): index of the last fully written buffer, updated together with frame_done.
- Undefined: single buffer only; disp_buf_sel is absent.

Test Plan:
- No frame_start, level = 200 -> req_valid stays 0 for 1000 cycles.
- frame_start, then level = 64, req_ready and wdata_ready tied high -> req_addr = 0; 64 beats on 64 consecutive cycles; wdata_last on beat 64 only; data order matches the FIFO; next req_addr = 64.
- Single burst with wdata_ready toggling 1-0-1-0 -> no lost or duplicated beat, wdata held during stalls, occupancy never exceeds 2; fifo_rd_empty pulsed mid-burst -> burst still ends with exactly 64 beats.
- FRAME_WORDS = 128, BURST_LEN = 64, 3 bursts -> frame_done pulses after burst 2; burst 3 req_addr = 0; with CAM_BURST_PINGPONG_EN the next frame's first req_addr = 128 and disp_buf_sel = 0.
- frame_start at beat 30 of the burst at address 64 -> burst completes with 64 beats; next req_addr = 0; no frame_done.
- rst at beat 10 -> next cycle all outputs 0; after frame_start and level = 64, req_addr = 0.

Source files
------------

// File: rtl/cam_fifo_burst_ctrl.sv
// rtl/cam_fifo_burst_ctrl.sv - camera FIFO read-side burst controller feeding the frame-buffer write port
//
// Purpose: waits until a full burst is buffered in the camera pixel FIFO, issues a
// frame-buffer write request, then streams exactly BURST_LEN beats through a
// 2-entry beat buffer. Tracks the frame write address, wraps at frame end and
// resynchronises on camera frame_start.
//
// Ports:
//   clk, rst                    clock (also FIFO rd_clk), synchronous active-high reset
//   frame_start                 one-cycle camera vsync pulse
//   fifo_rd_water_level/_empty  FIFO read-side status
//   fifo_rd_en / fifo_rd_data   FIFO read port, data valid one cycle after fifo_rd_en
//   req_valid/ready/addr/len    burst request channel (req_len = BURST_LEN-1)
//   wdata_valid/ready/wdata/_last  write beat channel
//   frame_done                  pulse when the last burst of a frame completes
//   busy                        high while a request or its data phase is active
//   disp_buf_sel                only with CAM_BURST_PINGPONG_EN: last fully written buffer
//
// Optional feature macro: CAM_BURST_PINGPONG_EN (double-buffered frame store).

module cam_fifo_burst_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEVEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_WORDS = 153600
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  input  logic                   fifo_rd_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  output logic [7:0]             req_len,
  output logic                   wdata_valid,
  input  logic                   wdata_ready,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic                   wdata_last,
  output logic                   frame_done,
  output logic                   busy
`ifdef CAM_BURST_PINGPONG_EN
  ,
  output logic                   disp_buf_sel
`endif
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE0 = ADDR_WIDTH'(FRAME_BASE);
  localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(FRAME_BASE + FRAME_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        next_count;
  logic                    armed;
  logic                    pending;
  logic [8:0]              rd_left;
  logic [7:0]              beat_cnt;

  logic [1:0]              occ;
  logic                    inflight;
  logic [DATA_WIDTH-1:0]   buf0;
  logic [DATA_WIDTH-1:0]   buf1;
  logic [2:0]              fill_after;
  logic                    pop;
  logic                    burst_end;
  logic                    wrap;

  logic [ADDR_WIDTH-1:0]   cur_base;
  logic [ADDR_WIDTH-1:0]   alt_base;

`ifdef CAM_BURST_PINGPONG_EN
  logic wr_sel;
  assign cur_base = wr_sel ? BASE1 : BASE0;
  // an applied frame_start switches to the other buffer
  assign alt_base = wr_sel ? BASE0 : BASE1;
`else
  assign cur_base = BASE0;
  assign alt_base = BASE0;
`endif

  assign req_len     = 8'(BURST_LEN - 1);
  assign req_addr    = addr;
  assign wdata_valid = (occ != 2'd0);
  assign wdata       = buf0;
  assign wdata_last  = wdata_valid && (beat_cnt == 8'(BURST_LEN - 1));
  assign pop         = wdata_valid && wdata_ready;
  assign burst_end   = pop && wdata_last;
  assign next_count  = count + CNT_W'(BURST_LEN);
  assign wrap        = (next_count == CNT_W'(FRAME_WORDS));

  // Buffer fill after this edge, counting the word already in flight; a new read
  // is only issued if that word will still have a slot when it lands.
  assign fill_after  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en  = (state == S_DATA) && (rd_left != 9'd0) && !fifo_rd_empty
                       && (fill_after < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= BASE0;
      count      <= '0;
      armed      <= 1'b0;
      pending    <= 1'b0;
      req_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      rd_left    <= 9'd0;
      beat_cnt   <= 8'd0;
`ifdef CAM_BURST_PINGPONG_EN
      wr_sel       <= 1'b1;
      disp_buf_sel <= 1'b1;
`endif
    end else begin
      frame_done <= 1'b0;
      if (frame_start) armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (frame_start || pending) begin
            addr    <= alt_base;
            count   <= '0;
            pending <= 1'b0;
`ifdef CAM_BURST_PINGPONG_EN
            wr_sel  <= ~wr_sel;
`endif
          end
          if (armed && (fifo_rd_water_level >= LEVEL_WIDTH'(BURST_LEN))) begin
            state     <= S_ADDR;
            req_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ADDR: begin
          if (frame_start) pending <= 1'b1;
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= S_DATA;
            rd_left   <= 9'(BURST_LEN);
            beat_cnt  <= 8'd0;
          end
        end
        S_DATA: begin
          if (fifo_rd_en) rd_left <= rd_left - 9'd1;
          if (pop) beat_cnt <= beat_cnt + 8'd1;
          if (burst_end) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            pending  <= 1'b0;
            beat_cnt <= 8'd0;
            if (wrap) begin
              frame_done <= 1'b1;
`ifdef CAM_BURST_PINGPONG_EN
              disp_buf_sel <= wr_sel;
`endif
            end
            // a frame_start seen during the burst wins over increment and wrap
            if (pending || frame_start) begin
              addr  <= alt_base;
              count <= '0;
`ifdef CAM_BURST_PINGPONG_EN
              wr_sel <= ~wr_sel;
`endif
            end else if (wrap) begin
              addr  <= cur_base;
              count <= '0;
            end else begin
              addr  <= addr + ADDR_WIDTH'(BURST_LEN);
              count <= next_count;
            end
          end else if (frame_start) begin
            pending <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // 2-entry beat buffer: buf0 is always the head presented on wdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_rd_data;
          else             buf1 <= fifo_rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_rd_data;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
